// File: rtl/vga_pkg.sv
// Shared VGA-pipeline types and constants; here the font-ROM arbiter pieces.
package vga_pkg;

    localparam int CHAR_ADDR_W = 11;
    localparam int CHAR_DATA_W = 8;
    localparam int GLYPH_LINES = 16;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    typedef struct packed {
        logic vld;
        logic id;
    } rom_tag_t;

endpackage

// File: rtl/char_rom_arbiter_tag_pipe.sv
// ROM_LAT-deep shift register of {valid, id} tags tracking in-flight ROM reads.
module char_rom_tag_pipe
    import vga_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_vld,
    input  logic     in_id,
    output rom_tag_t tag_out
);

    rom_tag_t pipe [ROM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= rom_tag_t'({in_vld, in_id & in_vld});
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[ROM_LAT-1];

endmodule

// File: rtl/char_rom_arbiter.sv
// Round-robin, burst-granular arbiter sharing one font ROM between two glyph sources.
// Optional stall counter port enabled by defining CHAR_ROM_ARB_STATS_EN.
module char_rom_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W    = CHAR_ADDR_W,
    parameter int DATA_W    = CHAR_DATA_W,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = GLYPH_LINES
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: a beat transfers in any cycle where valid & ready are both high;
    // valid, addr and last must stay stable until that cycle.
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_last,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef CHAR_ROM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_t state, state_next;
    logic       rr_ptr, rr_next;
    logic [7:0] beat_cnt, cnt_next, cnt_inc;
    logic       accept, acc_id, acc_last, release_burst;
    rom_tag_t   tag_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            beat_cnt <= cnt_next;
        end
    end

    always_comb begin
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        state_next    = state;
        rr_next       = rr_ptr;
        cnt_next      = beat_cnt;
        cnt_inc       = beat_cnt + 8'd1;

        // The winner in IDLE is granted combinationally so its first beat needs no bubble.
        case (state)
            ARB_IDLE: begin
                if (req0_valid && (!req1_valid || !rr_ptr)) req0_ready = 1'b1;
                else if (req1_valid)                        req1_ready = 1'b1;
            end
            ARB_OWN0: req0_ready = req0_valid;
            ARB_OWN1: req1_ready = req1_valid;
            default:  state_next = ARB_IDLE;
        endcase

        accept        = req0_ready | req1_ready;
        acc_id        = req1_ready;
        acc_last      = req1_ready ? req1_last : req0_last;
        release_burst = accept && (acc_last || cnt_inc == 8'(MAX_BURST));

        if (release_burst) begin
            state_next = ARB_IDLE;
            rr_next    = ~acc_id;
            cnt_next   = 8'd0;
        end else if (accept) begin
            state_next = acc_id ? ARB_OWN1 : ARB_OWN0;
            cnt_next   = cnt_inc;
        end
    end

    always_comb begin
        rom_addr = '0;
        if (req0_ready)      rom_addr = req0_addr;
        else if (req1_ready) rom_addr = req1_addr;
    end

    char_rom_tag_pipe #(.ROM_LAT(ROM_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (accept),
        .in_id   (acc_id),
        .tag_out (tag_out)
    );

    assign rsp0_valid = tag_out.vld & ~tag_out.id;
    assign rsp1_valid = tag_out.vld &  tag_out.id;
    assign rsp0_data  = rsp0_valid ? rom_data : '0;
    assign rsp1_data  = rsp1_valid ? rom_data : '0;

`ifdef CHAR_ROM_ARB_STATS_EN
    logic stall;
    assign stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    always_ff @(posedge clk) begin
        if (rst)                               stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Scoreboard bench for char_rom_arbiter: three instances cover default, MAX_BURST=4 and ROM_LAT=3.
module tb_char_rom_arbiter;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [10:0] req0_addr = '0, req1_addr = '0;
    logic        req0_last = 1'b0, req1_last = 1'b0;

    logic        req0_ready_a [3], req1_ready_a [3];
    logic        rsp0_valid_a [3], rsp1_valid_a [3];
    logic [7:0]  rsp0_data_a [3], rsp1_data_a [3], rom_data_a [3];
    logic [10:0] rom_addr_a [3];
    arb_state_t  st_a [3];
    logic        rr_a [3];
    logic [7:0]  cnt_a [3];
`ifdef CHAR_ROM_ARB_STATS_EN
    logic [15:0] stall_a [3];
`endif

    int sel = 0;
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [24:0] exp_q [$];
    int          acc0_q [$], acc1_q [$], idle_q [$];
    int          rsp_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int MB  = (g == 1) ? 4 : 16;
        logic [10:0] ap [LAT];

        char_rom_arbiter #(.ROM_LAT(LAT), .MAX_BURST(MB)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_addr  (req0_addr),
            .req0_last  (req0_last),
            .req0_ready (req0_ready_a[g]),
            .rsp0_valid (rsp0_valid_a[g]),
            .rsp0_data  (rsp0_data_a[g]),
            .req1_valid (req1_valid),
            .req1_addr  (req1_addr),
            .req1_last  (req1_last),
            .req1_ready (req1_ready_a[g]),
            .rsp1_valid (rsp1_valid_a[g]),
            .rsp1_data  (rsp1_data_a[g]),
            .rom_addr   (rom_addr_a[g]),
            .rom_data   (rom_data_a[g])
`ifdef CHAR_ROM_ARB_STATS_EN
            ,
            .stall_cnt  (stall_a[g])
`endif
        );

        // Font ROM model: registered read, LAT clocks deep.
        always @(posedge clk) begin
            ap[0] <= rom_addr_a[g];
            for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
        end
        assign rom_data_a[g] = rom_fn(ap[LAT-1]);
        assign st_a[g]  = dut.state;
        assign rr_a[g]  = dut.rr_ptr;
        assign cnt_a[g] = dut.beat_cnt;
    end

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0]  rsp0_data, rsp1_data;
    logic [10:0] rom_addr;
    assign req0_ready = req0_ready_a[sel];
    assign req1_ready = req1_ready_a[sel];
    assign rsp0_valid = rsp0_valid_a[sel];
    assign rsp1_valid = rsp1_valid_a[sel];
    assign rsp0_data  = rsp0_data_a[sel];
    assign rsp1_data  = rsp1_data_a[sel];
    assign rom_addr   = rom_addr_a[sel];

    // Monitor / scoreboard for the selected instance.
    logic [24:0] got, e;
    int          lat;
    always @(negedge clk) begin
        if (!rst) begin
            lat = (sel == 2) ? 3 : 1;
            if (rsp0_valid || rsp1_valid) begin
                n_vec++;
                got = {16'(cyc), rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data};
                if (rsp0_valid && rsp1_valid) begin
                    n_err++;
                    $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1, required at most one");
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got {cyc,id,data}=%h, required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL rsp: got {cyc,id,data}=%h, required %h", got, e);
                    end
                    rsp_cnt[rsp1_valid]++;
                end
            end
            n_vec++;
            if ((!rsp0_valid && rsp0_data !== 8'h0) || (!rsp1_valid && rsp1_data !== 8'h0)) begin
                n_err++;
                $display("FAIL rsp_data_idle: rsp0_data=%h rsp1_data=%h, required 0", rsp0_data, rsp1_data);
            end
            n_vec++;
            if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid) || (req0_ready && req1_ready)) begin
                n_err++;
                $display("FAIL ready_rule: ready0=%b ready1=%b valid0=%b valid1=%b", req0_ready, req1_ready, req0_valid, req1_valid);
            end
            n_vec++;
            if (req0_valid && req0_ready) begin
                exp_q.push_back({16'(cyc + lat), 1'b0, rom_fn(req0_addr)});
                acc0_q.push_back(cyc);
                if (rom_addr !== req0_addr) begin
                    n_err++;
                    $display("FAIL rom_addr0: got %h, required %h", rom_addr, req0_addr);
                end
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back({16'(cyc + lat), 1'b1, rom_fn(req1_addr)});
                acc1_q.push_back(cyc);
                if (rom_addr !== req1_addr) begin
                    n_err++;
                    $display("FAIL rom_addr1: got %h, required %h", rom_addr, req1_addr);
                end
            end else if (rom_addr !== 11'h0) begin
                n_err++;
                $display("FAIL rom_addr_idle: got %h, required 0", rom_addr);
            end
            if (st_a[sel] == ARB_IDLE) idle_q.push_back(cyc);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic send_beat(input bit id, input logic [10:0] addr, input logic last);
        int t;
        if (!id) begin req0_valid = 1'b1; req0_addr = addr; req0_last = last; end
        else     begin req1_valid = 1'b1; req1_addr = addr; req1_last = last; end
        t = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 100) begin
            n_err++;
            $display("FAIL ready_timeout: req%0d waited %0d cycles, required grant", id, t);
        end
        @(posedge clk);
        #1;
        if (!id) begin req0_valid = 1'b0; req0_last = 1'b0; end
        else     begin req1_valid = 1'b0; req1_last = 1'b0; end
    endtask

    task automatic burst(input bit id, input logic [10:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) send_beat(id, base + 11'(i), i == last_at);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        acc0_q.delete();
        acc1_q.delete();
        idle_q.delete();
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic check_int(input string name, input int got_v, input int exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got_v, exp_v);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            do_reset(s);
            n_vec++;
            if (st_a[s] !== ARB_IDLE || rr_a[s] !== 1'b0 || cnt_a[s] !== 8'd0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: state=%0d rr=%b cnt=%0d, required 0/0/0", s, st_a[s], rr_a[s], cnt_a[s]);
            end
            n_vec++;
            if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rom_addr, req0_ready, req1_ready} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: rsp_v=%b%b rom_addr=%h, required all 0", s, rsp0_valid, rsp1_valid, rom_addr);
            end
        end
    endtask

    task automatic test_single_req0();
        int t0;
        do_reset(0);
        t0 = cyc;
        burst(0, 11'h410, 16, 15);
        check_int("single_state_idle", int'(st_a[0] == ARB_IDLE), 1);
        repeat (3) @(posedge clk);
        #1;
        check_int("single_acc_count", acc0_q.size(), 16);
        if (acc0_q.size() == 16) begin
            check_int("single_first_acc", acc0_q[0], t0);
            check_int("single_last_acc", acc0_q[15], t0 + 15);
        end
        check_int("single_rsp0_count", rsp_cnt[0], 16);
        check_int("single_rsp1_count", rsp_cnt[1], 0);
        check_int("single_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_round_robin();
        int t0;
        do_reset(0);
        t0 = cyc;
        fork
            burst(0, 11'h100, 16, 15);
            burst(1, 11'h200, 16, 15);
        join
        repeat (3) @(posedge clk);
        #1;
        check_int("rr_acc0_count", acc0_q.size(), 16);
        check_int("rr_acc1_count", acc1_q.size(), 16);
        if (acc0_q.size() == 16 && acc1_q.size() == 16) begin
            check_int("rr_acc0_first", acc0_q[0], t0);
            check_int("rr_acc0_last", acc0_q[15], t0 + 15);
            check_int("rr_acc1_first", acc1_q[0], t0 + 16);
            check_int("rr_acc1_last", acc1_q[15], t0 + 31);
        end
        check_int("rr_idle_between", int'(t0 + 16 inside {idle_q}), 1);
        check_int("rr_ptr_end", int'(rr_a[0]), 0);
        check_int("rr_rsp_total", rsp_cnt[0] + rsp_cnt[1], 32);
    endtask

    task automatic test_bubble();
        int t0;
        do_reset(0);
        t0 = cyc;
        fork
            begin
                burst(0, 11'h300, 5, -1);
                repeat (3) @(posedge clk);
                #1;
                burst(0, 11'h305, 5, 4);
            end
            burst(1, 11'h020, 2, 1);
        join
        repeat (3) @(posedge clk);
        #1;
        check_int("bubble_acc0_count", acc0_q.size(), 10);
        if (acc0_q.size() == 10) check_int("bubble_resume", acc0_q[5], t0 + 8);
        check_int("bubble_acc1_count", acc1_q.size(), 2);
        if (acc1_q.size() == 2) check_int("bubble_req1_grant", acc1_q[0], t0 + 13);
        check_int("bubble_rsp_total", rsp_cnt[0] + rsp_cnt[1], 12);
    endtask

    task automatic test_max_burst();
        int t0;
        do_reset(1);
        t0 = cyc;
        burst(1, 11'h5A0, 10, 9);
        repeat (3) @(posedge clk);
        #1;
        check_int("mb_acc1_count", acc1_q.size(), 10);
        if (acc1_q.size() == 10) begin
            check_int("mb_first", acc1_q[0], t0);
            check_int("mb_last", acc1_q[9], t0 + 9);
        end
        check_int("mb_idle_after4", int'(t0 + 4 inside {idle_q}), 1);
        check_int("mb_idle_after8", int'(t0 + 8 inside {idle_q}), 1);
        check_int("mb_owned_mid", int'(t0 + 5 inside {idle_q}), 0);
        check_int("mb_rr_end", int'(rr_a[1]), 0);
        check_int("mb_rsp1_count", rsp_cnt[1], 10);
    endtask

    task automatic test_latency();
        do_reset(2);
        for (int i = 0; i < 6; i++) send_beat(i[0], 11'h040 + 11'(i * 37), 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_int("lat_rsp0_count", rsp_cnt[0], 3);
        check_int("lat_rsp1_count", rsp_cnt[1], 3);
        check_int("lat_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_reset_inflight();
        int a;
        do_reset(2);
        send_beat(1, 11'h2C3, 1'b1);
        a = (acc1_q.size() > 0) ? acc1_q[0] : -1;
        check_int("rstfl_accept", a, cyc - 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
        n_vec++;
        if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rom_addr, req0_ready, req1_ready} !== '0
            || st_a[2] !== ARB_IDLE) begin
            n_err++;
            $display("FAIL rstfl_outputs: rsp_v=%b%b rom_addr=%h state=%0d, required all 0", rsp0_valid, rsp1_valid, rom_addr, st_a[2]);
        end
        a = cyc;
        send_beat(0, 11'h611, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_int("rstfl_req0_acc_count", acc0_q.size(), 1);
        if (acc0_q.size() == 1) check_int("rstfl_req0_immediate", acc0_q[0], a);
        check_int("rstfl_rsp0_count", rsp_cnt[0], 1);
        check_int("rstfl_rsp1_count", rsp_cnt[1], 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_req0();
        test_round_robin();
        test_bubble();
        test_max_burst();
        test_latency();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/char_rom_arbiter.md
Name: char_rom_arbiter

Overview:
- Shares the single font/character ROM between two glyph-address sources.
  - Requester 0: board coordinate labels (A–H, 1–8).
  - Requester 1: the status/move-text overlay.
- Grants ROM access in glyph bursts (one glyph = 16 line fetches) with round-robin fairness.
- Returns each ROM line to the requester that issued it, after the ROM read latency.
- Sits between the letter/text address generators and the font ROM, in the pixel clock domain.

Parameters:
- ADDR_W, 11, ROM address width ({char_code[6:0], line[3:0]}).
- DATA_W, 8, ROM line width (pixels per glyph row).
- ROM_LAT, 1, ROM read latency in clocks; range 1..4.
- MAX_BURST, 16, maximum beats per ownership before forced release; range 1..255.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset.
- req0_valid  in  1  requester 0 beat valid.
- req0_addr  in  ADDR_W  requester 0 ROM address.
- req0_last  in  1  final beat of requester 0 burst.
- req0_ready  out  1  requester 0 beat accepted this cycle when valid.
- rsp0_valid  out  1  ROM data for requester 0 present.
- rsp0_data  out  DATA_W  ROM line for requester 0.
- req1_valid / req1_addr / req1_last / req1_ready / rsp1_valid / rsp1_data: same as requester 0, for requester 1.
- rom_addr  out  ADDR_W  address to font ROM.
- rom_data  in  DATA_W  font ROM output, valid ROM_LAT clocks after rom_addr.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge) returns the block to this state:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - Tag pipeline cleared; rsp*_valid=0, rsp*_data=0.
  - rom_addr=0 (combinationally 0 while no beat is accepted).
- FSM states are IDLE, OWN0 and OWN1.
- IDLE:
  - Winner selection: only one reqN_valid high → that N wins; both high → requester rr_ptr wins.
  - The winner's ready is high in the same cycle, so its first beat is accepted with no grant bubble.
  - Next state is OWN(winner), unless that beat has last=1 or MAX_BURST=1, in which case the burst is released.
- OWNn:
  - reqn_ready=1 and the other ready=0.
  - A beat is accepted when reqn_valid=1.
  - Ownership is held while valid=0 (bubbles allowed, no timeout).
- Release happens when an accepted beat has last=1, or when beat_cnt reaches MAX_BURST accepted beats.
  - On release: state→IDLE, rr_ptr←~n, beat_cnt←0.
  - The next grant is decided in the following cycle; one idle cycle between bursts is required.
- ready is never high for a requester whose valid is low. The interface is AXI-style: valid must hold with stable addr/last until ready.
- rom_addr is combinational: the accepted beat's addr, else 0.
- Tag pipeline: shift register of ROM_LAT entries of {valid, id}.
  - rspN_valid=1 exactly ROM_LAT clocks after the accept cycle when the tag id=N.
  - rspN_data=rom_data while rspN_valid, else 0.
  - Responses preserve accept order; at most one response per cycle.
- beat_cnt is 8 bits. It counts accepted beats in the current ownership and never wraps, because release occurs at MAX_BURST.
- rst during a burst: ownership is dropped, in-flight tags are discarded, and no rsp*_valid occurs afterwards for those beats.
- last=1 together with beat_cnt hitting MAX_BURST: a single release; rr_ptr flips once.

Optional Feature:
- Macro: CHAR_ROM_ARB_STATS_EN.
- When defined, adds output port stall_cnt[15:0]:
  - Counts cycles where (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready).
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: the port and counter are absent; functional behaviour is otherwise identical.

Decomposition:
- vga_pkg gains:
  - localparams CHAR_ADDR_W=11, CHAR_DATA_W=8, GLYPH_LINES=16.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t.
  - typedef struct packed {logic vld; logic id;} rom_tag_t.
- One sub-module is natural: char_rom_tag_pipe, a ROM_LAT-deep tag shift register with sync reset, which produces rsp valids.

Test Plan:
- Only req0 valid, addr 0x410..0x41F, last on 16th beat → ready every cycle from cycle 0. rom_addr follows those addresses. rsp0_valid for 16 consecutive cycles starting at cycle ROM_LAT. rsp1_valid never asserts. State returns to IDLE.
- Both valid from reset (rr_ptr=0), 16-beat bursts each → req0 served first; one idle cycle; then req1's 16 beats; rr_ptr ends at 0 again.
- req0 owns and drops valid for 3 cycles mid-burst while req1 is valid → req1_ready stays 0 throughout; req0 resumes and finishes; req1 is granted only after the release cycle.
- MAX_BURST=4, req1 streams 10 beats with last=0 → forced release after 4 beats; with req0 idle, req1 is re-granted after one idle cycle. Beats arrive 4/4/2 (last on beat 10).
- ROM_LAT=3, alternating single-beat bursts (last=1) from 0 and 1 → each rsp valid arrives exactly 3 clocks after its accept, routed to the correct id, data matching the ROM model.
- rst pulsed 2 cycles after a req1 accept (ROM_LAT=3) → no rsp1_valid for that beat; all outputs 0 the cycle after reset; a fresh req0 is granted immediately afterwards.
